pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage rv32 pipeline. It turns load-use hazards, multi-cycle mul/div occupancy of EX, data-memory wait states and EX-resolved redirects into per-stage enables, bubble injections and flushes. It also keeps saturating stall and flush counters for performance monitoring. It sits beside the forwarding logic. Forwarding resolves ALU-to-ALU dependencies; this block handles every case that needs the pipeline to stop or squash.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- id_rs1_i  in  5  rs1 of the instruction in ID
- id_rs2_i  in  5  rs2 of the instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- id_ex_rd_i  in  5  rd of the instruction in EX
- id_ex_is_load_i  in  1  EX instruction is a load
- md_start_i  in  1  EX holds a mul/div op
- md_done_i  in  1  mul/div result valid; held high until EX advances
- dmem_req_i  in  1  MM holds a memory access
- dmem_ack_i  in  1  data memory completes the access this cycle
- redirect_i  in  1  taken branch/jump/trap resolved in EX
- pc_en_o  out  1  PC update enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  IF/ID loads a bubble
- id_ex_en_o  out  1  ID/EX register enable
- id_ex_flush_o  out  1  ID/EX loads a bubble
- ex_mm_en_o  out  1  EX/MM register enable
- ex_mm_flush_o  out  1  EX/MM loads a bubble
- mm_wb_en_o  out  1  MM/WB register enable
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating
- flush_cnt_o  out  CNT_W  accepted redirects, saturating

## Operation
- States: RUN, MD_WAIT, MEM_WAIT. The state register is the only sequential element besides the two counters.
- The flush outputs only take effect when the corresponding enable is 1. The block never drives flush=1 with en=0.

Priority in RUN (first match wins; outputs not listed are en=1, flush=0):
1. memfrz = dmem_req_i & ~dmem_ack_i:
   - All enables 0, all flushes 0. Next state MEM_WAIT.
   - Redirect and load-use are suppressed and re-evaluated on a later cycle.
2. md_start_i & ~md_done_i:
   - pc/if_id/id_ex en=0; ex_mm_flush=1. Next state MD_WAIT.
   - If redirect_i is also high it is ignored; the two are exclusive by construction.
3. redirect_i:
   - if_id_flush=1, id_ex_flush=1, all enables 1.
   - flush_cnt increments.
4. Load-use: id_ex_is_load_i & id_ex_rd_i≠0 & ((id_uses_rs1_i & id_rs1_i==id_ex_rd_i) | (id_uses_rs2_i & id_rs2_i==id_ex_rd_i)):
   - pc_en=0, if_id_en=0, id_ex_flush=1.
5. Otherwise all enables 1.

MEM_WAIT:
- While memfrz holds: full freeze.
- On dmem_ack_i: outputs equal RUN priorities 2–5 evaluated that cycle, and the next state follows from them (RUN or MD_WAIT).

MD_WAIT:
- memfrz: full freeze, stay in MD_WAIT.
- Else if ~md_done_i: pc/if_id/id_ex en=0, ex_mm_flush=1 (a bubble flows to MM/WB).
- Else (md_done_i): all en=1, no flush, next state RUN.

Counters:
- stall_cnt increments on every cycle with pc_en_o=0.
- flush_cnt increments on every accepted redirect.
- Both saturate at all-ones and do not wrap.

## Timing
- Every output is combinational from the current state and inputs in the same cycle. The state and counters update on the rising clk_i.
- While rst_i is high:
  - State is RUN and both counters are 0.
  - All *_en_o and *_flush_o outputs are 0.
- Reset takes effect immediately (asynchronous) and may be asserted mid-stall. The first cycle after release behaves as RUN.
- Load-use: exactly 1 stall cycle. The dependent instruction re-enters ID the next cycle and finds the load in MM, so the forwarding path covers it.
- Mul/div:
  - md_start_i rises at cycle 0 and md_done_i first rises at cycle k.
  - pc_en_o is 0 for cycles 0..k-1 and 1 at cycle k.
  - That adds k to stall_cnt and sends k bubbles into EX/MM.
  - md_start_i with md_done_i already high on the same cycle causes no stall.
- Memory: an n-cycle wait (ack at cycle n) freezes all stages for cycles 0..n-1.
- Simultaneous events resolve by the priority order above. memfrz dominates in every state.

## Test plan
- Load-use: EX holds lw x5 and ID holds add x6,x5,x7 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then all enables 1; stall_cnt=1. Repeat with rd=x0 → no stall.
- Mul/div: md_start_i=1 and md_done_i rises 4 cycles later → pc_en low for 4 cycles, ex_mm_flush high for 4 cycles, state returns to RUN; stall_cnt=4.
- Memory wait: dmem_req_i=1 with ack after 3 cycles, while a redirect is pending in EX → 3 full-freeze cycles, then the redirect flush fires on the ack cycle; flush_cnt=1.
- Memory wait during MD_WAIT: a mem freeze while md_done_i=1 → full freeze, state stays MD_WAIT; after ack, all enables 1 and state RUN.
- Saturation: preload by running a continuous stall with CNT_W=4 → stall_cnt holds at 15.
- Reset: assert rst_i mid-MD_WAIT → outputs go to 0 immediately and counters clear; after release the block behaves as RUN.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage rv32 pipeline: turns hazards, mul/div
// occupancy, memory wait states and redirects into stage enables, bubbles and flushes.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic             id_ex_is_load_i,
  input  logic             md_start_i,
  input  logic             md_done_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             redirect_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mm_en_o,
  output logic             ex_mm_flush_o,
  output logic             mm_wb_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic memfrz;
  logic md_stall;
  logic load_use;
  logic redirect_take;

  assign memfrz   = dmem_req_i & ~dmem_ack_i;
  assign md_stall = md_start_i & ~md_done_i;
  assign load_use = id_ex_is_load_i && (id_ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == id_ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == id_ex_rd_i)));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; MEM_WAIT resolves exactly like RUN once the ack arrives
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_WAIT: begin
        if (!memfrz && md_done_i) state_next = RUN;
      end
      default: begin
        if (memfrz)        state_next = MEM_WAIT;
        else if (md_stall) state_next = MD_WAIT;
        else               state_next = RUN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_en_o    = 1'b1;
    id_ex_flush_o = 1'b0;
    ex_mm_en_o    = 1'b1;
    ex_mm_flush_o = 1'b0;
    mm_wb_en_o    = 1'b1;
    redirect_take = 1'b0;

    case (state_reg)
      MD_WAIT: begin
        if (memfrz) begin
          pc_en_o    = 1'b0;
          if_id_en_o = 1'b0;
          id_ex_en_o = 1'b0;
          ex_mm_en_o = 1'b0;
          mm_wb_en_o = 1'b0;
        end else if (!md_done_i) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_en_o    = 1'b0;
          ex_mm_flush_o = 1'b1;
        end
      end
      default: begin
        if (memfrz) begin
          pc_en_o    = 1'b0;
          if_id_en_o = 1'b0;
          id_ex_en_o = 1'b0;
          ex_mm_en_o = 1'b0;
          mm_wb_en_o = 1'b0;
        end else if (md_stall) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_en_o    = 1'b0;
          ex_mm_flush_o = 1'b1;
        end else if (redirect_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          redirect_take = 1'b1;
        end else if (load_use) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end
      end
    endcase

    // Hold every stage quiet while reset is asserted
    if (rst_i) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_en_o    = 1'b0;
      id_ex_flush_o = 1'b0;
      ex_mm_en_o    = 1'b0;
      ex_mm_flush_o = 1'b0;
      mm_wb_en_o    = 1'b0;
      redirect_take = 1'b0;
    end
  end

  // Saturating performance counters: index 0 = stall cycles, 1 = accepted redirects
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = ~pc_en_o;
  assign cnt_inc[1] = redirect_take;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt_o = cnt_reg[0];
  assign flush_cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a behavioural model; a second instance with 4-bit counters covers saturation.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_ex_rd_i;
  logic       id_uses_rs1_i, id_uses_rs2_i, id_ex_is_load_i;
  logic       md_start_i, md_done_i, dmem_req_i, dmem_ack_i, redirect_i;

  logic        pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
  logic        ex_mm_en_o, ex_mm_flush_o, mm_wb_en_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
  logic        s_ex_mm_en, s_ex_mm_flush, s_mm_wb_en;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mm_en, ex_mm_flush, mm_wb_en
  localparam logic [7:0] ALL_EN = 8'hD5;
  localparam logic [7:0] FREEZE = 8'h00;
  localparam logic [7:0] MDBUB  = 8'h07;
  localparam logic [7:0] REDIR  = 8'hFD;
  localparam logic [7:0] LDUSE  = 8'h1D;

  logic [7:0] outs, s_outs;
  assign outs   = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
                   ex_mm_en_o, ex_mm_flush_o, mm_wb_en_o};
  assign s_outs = {s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush,
                   s_ex_mm_en, s_ex_mm_flush, s_mm_wb_en};

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_ex_rd_i(id_ex_rd_i), .id_ex_is_load_i(id_ex_is_load_i),
    .md_start_i(md_start_i), .md_done_i(md_done_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .redirect_i(redirect_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_en_o(id_ex_en_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mm_en_o(ex_mm_en_o), .ex_mm_flush_o(ex_mm_flush_o), .mm_wb_en_o(mm_wb_en_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_small (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_ex_rd_i(id_ex_rd_i), .id_ex_is_load_i(id_ex_is_load_i),
    .md_start_i(md_start_i), .md_done_i(md_done_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .redirect_i(redirect_i),
    .pc_en_o(s_pc_en), .if_id_en_o(s_if_id_en), .if_id_flush_o(s_if_id_flush),
    .id_ex_en_o(s_id_ex_en), .id_ex_flush_o(s_id_ex_flush),
    .ex_mm_en_o(s_ex_mm_en), .ex_mm_flush_o(s_ex_mm_flush), .mm_wb_en_o(s_mm_wb_en),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic idle_inputs();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; id_ex_is_load_i = 1'b0;
    md_start_i = 1'b0; md_done_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0; redirect_i = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, with reset released
  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== FREEZE || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: outs=%h stall=%0d flush=%0d, required outs=%h counters=0",
               outs, stall_cnt_o, flush_cnt_o, FREEZE);
    end
    $display("test_reset: outs=%h stall=%0d flush=%0d", outs, stall_cnt_o, flush_cnt_o);
    advance();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN) begin
      n_fail++;
      $display("FAIL reset_release: outs=%h, required %h", outs, ALL_EN);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    // EX: lw x5 ; ID: add x6,x5,x7
    id_ex_is_load_i = 1'b1; id_ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_rs2_i = 5'd7; id_uses_rs1_i = 1'b1; id_uses_rs2_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== LDUSE) begin
      n_fail++;
      $display("FAIL load_use_stall: outs=%h, required %h", outs, LDUSE);
    end
    $display("test_load_use: rd=x5 outs=%h", outs);
    advance();
    id_ex_is_load_i = 1'b0; id_ex_rd_i = 5'd6;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN || stall_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL load_use_release: outs=%h stall=%0d, required %h stall=1",
               outs, stall_cnt_o, ALL_EN);
    end
    advance();
    // rs2 match only
    id_ex_is_load_i = 1'b1; id_ex_rd_i = 5'd7; id_rs1_i = 5'd3;
    @(negedge clk_i);
    n_checks++;
    if (outs !== LDUSE) begin
      n_fail++;
      $display("FAIL load_use_rs2: outs=%h, required %h", outs, LDUSE);
    end
    advance();
    // x0 destination never stalls
    id_ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN) begin
      n_fail++;
      $display("FAIL load_use_x0: outs=%h, required %h", outs, ALL_EN);
    end
    advance();
    @(negedge clk_i);
    n_checks++;
    if (stall_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL load_use_count: stall=%0d, required 2", stall_cnt_o);
    end
    $display("test_load_use: x0 outs=%h stall=%0d", outs, stall_cnt_o);
    advance();
  endtask

  task automatic test_muldiv();
    do_reset();
    md_start_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (outs !== MDBUB) begin
        n_fail++;
        $display("FAIL md_bubble_c%0d: outs=%h, required %h", c, outs, MDBUB);
      end
      advance();
    end
    md_done_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN || stall_cnt_o !== 32'd4) begin
      n_fail++;
      $display("FAIL md_done: outs=%h stall=%0d, required %h stall=4", outs, stall_cnt_o, ALL_EN);
    end
    advance();
    // Back in RUN: a redirect is accepted
    md_start_i = 1'b0; md_done_i = 1'b0; redirect_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== REDIR) begin
      n_fail++;
      $display("FAIL md_back_to_run: outs=%h, required %h", outs, REDIR);
    end
    advance();
    redirect_i = 1'b0; md_start_i = 1'b1; md_done_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN) begin
      n_fail++;
      $display("FAIL md_already_done: outs=%h, required %h", outs, ALL_EN);
    end
    $display("test_muldiv: k=4 stall=%0d flush=%0d", stall_cnt_o, flush_cnt_o);
    advance();
  endtask

  task automatic test_mem_redirect();
    do_reset();
    dmem_req_i = 1'b1; redirect_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (outs !== FREEZE) begin
        n_fail++;
        $display("FAIL mem_freeze_c%0d: outs=%h, required %h", c, outs, FREEZE);
      end
      advance();
    end
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== REDIR) begin
      n_fail++;
      $display("FAIL mem_ack_redirect: outs=%h, required %h", outs, REDIR);
    end
    advance();
    idle_inputs();
    @(negedge clk_i);
    n_checks++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd3) begin
      n_fail++;
      $display("FAIL mem_counts: flush=%0d stall=%0d, required flush=1 stall=3",
               flush_cnt_o, stall_cnt_o);
    end
    $display("test_mem_redirect: flush=%0d stall=%0d", flush_cnt_o, stall_cnt_o);
    advance();
  endtask

  task automatic test_mem_in_md();
    do_reset();
    md_start_i = 1'b1;
    advance();
    md_done_i = 1'b1; dmem_req_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== FREEZE) begin
      n_fail++;
      $display("FAIL md_mem_freeze: outs=%h, required %h", outs, FREEZE);
    end
    advance();
    // Still in MD_WAIT: redirect ignored, everything enabled
    dmem_ack_i = 1'b1; md_start_i = 1'b0; redirect_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== ALL_EN) begin
      n_fail++;
      $display("FAIL md_mem_ack: outs=%h, required %h", outs, ALL_EN);
    end
    advance();
    idle_inputs();
    redirect_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs !== REDIR) begin
      n_fail++;
      $display("FAIL md_mem_run: outs=%h, required %h", outs, REDIR);
    end
    $display("test_mem_in_md: outs=%h", outs);
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    md_start_i = 1'b1;
    repeat (20) advance();
    @(negedge clk_i);
    n_checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt_o !== 32'd20) begin
      n_fail++;
      $display("FAIL saturation: small=%0d wide=%0d, required 15 and 20", s_stall_cnt, stall_cnt_o);
    end
    $display("test_saturation: small=%0d wide=%0d", s_stall_cnt, stall_cnt_o);
    advance();
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    md_start_i = 1'b1;
    advance();
    advance();
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (outs !== FREEZE || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_md: outs=%h stall=%0d flush=%0d, required %h and 0",
               outs, stall_cnt_o, flush_cnt_o, FREEZE);
    end
    md_start_i = 1'b0; redirect_i = 1'b1;
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    n_checks++;
    if (outs !== REDIR) begin
      n_fail++;
      $display("FAIL reset_mid_md_run: outs=%h, required %h", outs, REDIR);
    end
    advance();
    redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_md_count: flush=%0d stall=%0d, required 1 and 0",
               flush_cnt_o, stall_cnt_o);
    end
    $display("test_reset_mid_md: flush=%0d stall=%0d", flush_cnt_o, stall_cnt_o);
    advance();
  endtask

  task automatic test_random();
    bit         md_busy = 1'b0;   // a mul/div op has started and not yet finished
    int         stalls  = 0;
    int         flushes = 0;
    logic [7:0] exp;
    bit         taken, nbusy, frz, lu;
    int         errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      dmem_req_i      = ($urandom_range(0, 3) == 0);
      dmem_ack_i      = 1'($urandom_range(0, 1));
      md_start_i      = ($urandom_range(0, 4) == 0);
      md_done_i       = ($urandom_range(0, 2) == 0);
      redirect_i      = ($urandom_range(0, 5) == 0);
      id_ex_is_load_i = 1'($urandom_range(0, 1));
      id_ex_rd_i      = 5'($urandom_range(0, 3));
      id_rs1_i        = 5'($urandom_range(0, 3));
      id_rs2_i        = 5'($urandom_range(0, 3));
      id_uses_rs1_i   = 1'($urandom_range(0, 1));
      id_uses_rs2_i   = 1'($urandom_range(0, 1));

      frz = dmem_req_i && !dmem_ack_i;
      lu  = id_ex_is_load_i && id_ex_rd_i != 0 &&
            ((id_uses_rs1_i && id_rs1_i == id_ex_rd_i) || (id_uses_rs2_i && id_rs2_i == id_ex_rd_i));
      exp = ALL_EN; taken = 1'b0; nbusy = md_busy;
      if (frz)                            exp = FREEZE;
      else if (md_busy)                   begin if (!md_done_i) exp = MDBUB; else nbusy = 1'b0; end
      else if (md_start_i && !md_done_i)  begin exp = MDBUB; nbusy = 1'b1; end
      else if (redirect_i)                begin exp = REDIR; taken = 1'b1; end
      else if (lu)                        exp = LDUSE;

      @(negedge clk_i);
      n_checks++;
      if (outs !== exp || s_outs !== exp) begin
        n_fail++; errs++;
        $display("FAIL rand_outs_%0d: outs=%h small=%h, required %h", i, outs, s_outs, exp);
      end
      n_checks++;
      if (stall_cnt_o !== 32'(stalls) || flush_cnt_o !== 32'(flushes) ||
          s_stall_cnt !== 4'((stalls > 15) ? 15 : stalls) ||
          s_flush_cnt !== 4'((flushes > 15) ? 15 : flushes)) begin
        n_fail++; errs++;
        $display("FAIL rand_cnt_%0d: stall=%0d flush=%0d small=%0d/%0d, required %0d/%0d (sat 15)",
                 i, stall_cnt_o, flush_cnt_o, s_stall_cnt, s_flush_cnt, stalls, flushes);
      end
      if (!exp[7]) stalls++;
      if (taken)   flushes++;
      md_busy = nbusy;
      advance();
    end
    $display("test_random: 400 cycles stall=%0d flush=%0d errors=%0d", stalls, flushes, errs);
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_muldiv();
    test_mem_redirect();
    test_mem_in_md();
    test_saturation();
    test_reset_mid_md();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
